// File: rtl/io_fifo_port.sv
// io_fifo_port: FIFO-buffered bridge between the CPU and a UM245R USB FIFO chip.
// Independent TX/RX circular queues plus a strobe-timing FSM toward the device.
module io_fifo_port #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic             system_clk,
    input  logic             _MR,
    input  logic             _tx_wr,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             _rx_rd,
    output logic [WIDTH-1:0] rx_data,
    output logic             _flag_do,
    output logic             _flag_di,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] dev_d_out,
    output logic             dev_d_oe,
    input  logic [WIDTH-1:0] dev_d_in,
    output logic             dev_wr,
    output logic             _dev_rd,
    input  logic             _dev_txe,
    input  logic             _dev_rxf
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_PULSE,
        TX_END,
        RX_PULSE,
        RX_END
    } state_e;

    // Reset release synchroniser; the FSM only starts once run is high.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       run;

    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [WIDTH-1:0] rx_mem [DEPTH];

    logic [PTR_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PTR_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop;
    logic [WIDTH-1:0] tx_head, rx_head;

    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rx_last_q, rx_last_d;
    logic [WIDTH-1:0] rx_cap_q, rx_cap_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_last_q, tx_last_d;
    logic             tx_elig, rx_elig;

    logic             dev_wr_q, dev_wr_d;
    logic             dev_rd_n_q, dev_rd_n_d;
    logic             dev_d_oe_q, dev_d_oe_d;
    logic [WIDTH-1:0] dev_d_out_q, dev_d_out_d;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign run        = rst_sync_q[1];

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[IDX_W-1:0] == tx_rp_q[IDX_W-1:0]) && (tx_wp_q[IDX_W] != tx_rp_q[IDX_W]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[IDX_W-1:0] == rx_rp_q[IDX_W-1:0]) && (rx_wp_q[IDX_W] != rx_rp_q[IDX_W]);

    assign tx_head = tx_mem[tx_rp_q[IDX_W-1:0]];
    assign rx_head = rx_mem[rx_rp_q[IDX_W-1:0]];

    // A pop on an empty queue never happens, so a same-cycle push always wins there.
    assign tx_push = !_tx_wr && !tx_full;
    assign tx_pop  = (state_q == TX_END) && !tx_empty;
    assign rx_push = (state_q == RX_END) && !rx_full;
    assign rx_pop  = !_rx_rd && !rx_empty;

    assign tx_elig = !tx_empty && !_dev_txe;
    assign rx_elig = !rx_full && !_dev_rxf;

    // NOTE: every signal assigned here gets a default first, so no latches are inferred.
    always_comb begin
        tx_wp_d     = tx_wp_q;
        tx_rp_d     = tx_rp_q;
        rx_wp_d     = rx_wp_q;
        rx_rp_d     = rx_rp_q;
        rx_last_d   = rx_last_q;
        overflow_d  = overflow_q | (!_tx_wr && tx_full);
        underflow_d = underflow_q | (!_rx_rd && rx_empty);
        if (tx_push) tx_wp_d = tx_wp_q + PTR_W'(1);
        if (tx_pop)  tx_rp_d = tx_rp_q + PTR_W'(1);
        if (rx_push) rx_wp_d = rx_wp_q + PTR_W'(1);
        if (rx_pop) begin
            rx_rp_d   = rx_rp_q + PTR_W'(1);
            rx_last_d = rx_head;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_last_d = tx_last_q;
        rx_cap_d  = rx_cap_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run) begin
                    // Round-robin when both sides are eligible; tx_last_q resets low so TX goes first.
                    if (tx_elig && (!rx_elig || !tx_last_q)) begin
                        state_d   = TX_PULSE;
                        tx_last_d = 1'b1;
                    end else if (rx_elig) begin
                        state_d   = RX_PULSE;
                        tx_last_d = 1'b0;
                    end
                end
            end
            TX_PULSE: begin
                if (cnt_q == CNT_LAST) state_d = TX_END;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            TX_END:   state_d = IDLE;
            RX_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = RX_END;
                    rx_cap_d = dev_d_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_END:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Device pins are registered copies of the next state, so they change with the state itself.
    always_comb begin
        dev_wr_d    = (state_d == TX_PULSE);
        dev_d_oe_d  = (state_d == TX_PULSE) || (state_d == TX_END);
        dev_rd_n_d  = (state_d != RX_PULSE);
        dev_d_out_d = dev_d_out_q;
        if (state_q == IDLE && state_d == TX_PULSE) dev_d_out_d = tx_head;
    end

    // NOTE: queue storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge system_clk) begin
        if (tx_push) tx_mem[tx_wp_q[IDX_W-1:0]] <= tx_data;
        if (rx_push) rx_mem[rx_wp_q[IDX_W-1:0]] <= rx_cap_q;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge system_clk or negedge _MR) begin
        if (!_MR) begin
            rst_sync_q  <= '0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rx_last_q   <= '0;
            rx_cap_q    <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_last_q   <= 1'b0;
            dev_wr_q    <= 1'b0;
            dev_rd_n_q  <= 1'b1;
            dev_d_oe_q  <= 1'b0;
            dev_d_out_q <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rx_last_q   <= rx_last_d;
            rx_cap_q    <= rx_cap_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_last_q   <= tx_last_d;
            dev_wr_q    <= dev_wr_d;
            dev_rd_n_q  <= dev_rd_n_d;
            dev_d_oe_q  <= dev_d_oe_d;
            dev_d_out_q <= dev_d_out_d;
        end
    end

    assign rx_data   = rx_empty ? rx_last_q : rx_head;
    assign _flag_do  = tx_full;
    assign _flag_di  = rx_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign dev_wr    = dev_wr_q;
    assign _dev_rd   = dev_rd_n_q;
    assign dev_d_oe  = dev_d_oe_q;
    assign dev_d_out = dev_d_out_q;

endmodule
